fact8_twiddle_conj_pipe: RTL and testbench

- Registered, handshaked trivial-twiddle stage for the factor-8 (j<6 or 8<=j<14 → ×1, else rotate) step, supporting both directions.
- Forward frames apply ×(−j) on rotated lanes; inverse frames apply the conjugate ×(+j), undoing the forward stage for the IFFT path.
- Frames are 64 points, delivered as 4 beats of 16 lanes.
- Sits between the radix butterfly output register and the next butterfly; carries frame framing and flags framing errors.

---
 rtl/fact8_twiddle_conj_pipe_if.sv | 32 +++
 rtl/fact8_twiddle_conj_pipe.sv | 147 ++++++++++++++
 tb/tb_fact8_twiddle_conj_pipe.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fact8_twiddle_conj_pipe_if.sv
// Handshake bundle for the factor-8 trivial-twiddle stage.
// slave = the stage itself, master = the upstream/downstream side.
interface fact8_twiddle_conj_pipe_if #(
    parameter int DATA  = 10,
    parameter int ARRAY = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sof;
    logic                  in_inv;
    logic [DATA*ARRAY-1:0] re;
    logic [DATA*ARRAY-1:0] im;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sof;
    logic                  out_eof;
    logic [DATA*ARRAY-1:0] re_m;
    logic [DATA*ARRAY-1:0] im_m;
    logic                  frm_err;

    modport slave (
        input  in_valid, in_sof, in_inv, re, im, out_ready,
        output in_ready, out_valid, out_sof, out_eof,
        output re_m, im_m, frm_err
    );

    modport master (
        output in_valid, in_sof, in_inv, re, im, out_ready,
        input  in_ready, out_valid, out_sof, out_eof,
        input  re_m, im_m, frm_err
    );
endinterface

// File: rtl/fact8_twiddle_conj_pipe.sv
// Registered factor-8 trivial twiddle (x-j forward, x+j inverse) with framing.
// FACT8_TWF_SATURATE_EN: negating the most negative sample saturates.
module fact8_twiddle_conj_pipe #(
    parameter int DATA  = 10,
    parameter int ARRAY = 16,
    parameter int BEATS = 4
) (
    input logic                       clk,
    input logic                       rstn,
    fact8_twiddle_conj_pipe_if.slave  bus
);
    localparam int W  = DATA * ARRAY;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          out_valid_q, out_valid_d;
    logic          out_sof_q, out_sof_d;
    logic          out_eof_q, out_eof_d;
    logic          frm_err_q, frm_err_d;
    logic [W-1:0]  re_m_q, re_m_d;
    logic [W-1:0]  im_m_q, im_m_d;

    logic         in_fire;
    logic         out_fire;
    logic         is_run;
    logic         is_last;
    logic         dir_eff;
    logic [W-1:0] rot_re;
    logic [W-1:0] rot_im;

    function automatic logic [DATA-1:0] neg(input logic [DATA-1:0] x);
`ifdef FACT8_TWF_SATURATE_EN
        if (x == {1'b1, {(DATA-1){1'b0}}})
            neg = {1'b0, {(DATA-1){1'b1}}};
        else
            neg = -x;
`else
        neg = -x;
`endif
    endfunction

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;
    assign bus.re_m      = re_m_q;
    assign bus.im_m      = im_m_q;
    assign bus.frm_err   = frm_err_q;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = out_valid_q && bus.out_ready;
    assign is_run   = (state_q == RUN);
    assign is_last  = (cnt_q == LAST);

    // A sof beat always uses its own in_inv; stray beats in IDLE run forward.
    assign dir_eff = bus.in_sof ? bus.in_inv : (is_run && dir_q);

    always_comb begin
        rot_re = bus.re;
        rot_im = bus.im;
        for (int j = 0; j < ARRAY; j++) begin
            if ((j % 8) >= 6) begin
                if (dir_eff) begin
                    rot_re[j*DATA +: DATA] = neg(bus.im[j*DATA +: DATA]);
                    rot_im[j*DATA +: DATA] = bus.re[j*DATA +: DATA];
                end else begin
                    rot_re[j*DATA +: DATA] = bus.im[j*DATA +: DATA];
                    rot_im[j*DATA +: DATA] = neg(bus.re[j*DATA +: DATA]);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        frm_err_d   = frm_err_q;
        out_valid_d = out_valid_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        re_m_d      = re_m_q;
        im_m_d      = im_m_q;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_sof_d   = 1'b0;
            out_eof_d   = 1'b0;
            re_m_d      = rot_re;
            im_m_d      = rot_im;
            unique case (1'b1)
                bus.in_sof: begin
                    if (is_run)
                        frm_err_d = 1'b1;
                    dir_d     = bus.in_inv;
                    out_sof_d = 1'b1;
                    cnt_d     = CW'(1);
                    state_d   = RUN;
                end
                !bus.in_sof && !is_run: begin
                    frm_err_d = 1'b1;
                end
                !bus.in_sof && is_run && is_last: begin
                    out_eof_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
                !bus.in_sof && is_run && !is_last: begin
                    cnt_d = cnt_q + CW'(1);
                end
            endcase
        end else if (out_fire) begin
            out_valid_d = 1'b0;
            out_sof_d   = 1'b0;
            out_eof_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            frm_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            re_m_q      <= '0;
            im_m_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            frm_err_q   <= frm_err_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            re_m_q      <= re_m_d;
            im_m_q      <= im_m_d;
        end
    end
endmodule

// File: tb/tb_fact8_twiddle_conj_pipe.sv
// Scoreboard bench for fact8_twiddle_conj_pipe: directed frames with
// hand-computed lane results, checked by an independent output monitor.
module tb_fact8_twiddle_conj_pipe;
    typedef logic [159:0] vec_t;
    typedef struct {
        logic sof;
        logic eof;
        logic err;
        vec_t re;
        vec_t im;
    } exp_t;

`ifdef FACT8_TWF_SATURATE_EN
    localparam int SATV = 511;
`else
    localparam int SATV = -512;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   acc = 0;
    int   beat_no = 0;
    exp_t q[$];

    fact8_twiddle_conj_pipe_if #(.DATA(10), .ARRAY(16)) bus ();

    fact8_twiddle_conj_pipe #(.DATA(10), .ARRAY(16), .BEATS(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Populated lanes: 0, 5, 6, 7, 13, 14, 15; all others zero.
    function automatic vec_t mk(input int l0, l5, l6, l7, l13, l14, l15);
        vec_t v;
        v = '0;
        v[0*10 +: 10]  = 10'(l0);
        v[5*10 +: 10]  = 10'(l5);
        v[6*10 +: 10]  = 10'(l6);
        v[7*10 +: 10]  = 10'(l7);
        v[13*10 +: 10] = 10'(l13);
        v[14*10 +: 10] = 10'(l14);
        v[15*10 +: 10] = 10'(l15);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp_v);
        end
    endtask

    task automatic send(input logic sof, inv, input vec_t re, im,
                        input logic esof, eeof, eerr, input vec_t ere, eim);
        int   w;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_inv   = inv;
        bus.re       = re;
        bus.im       = im;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_ready timeout act=0 exp=1");
        end else begin
            e.sof = esof;
            e.eof = eeof;
            e.err = eerr;
            e.re  = ere;
            e.im  = eim;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        acc++;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rstn && bus.out_valid) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat act=1 exp=0");
            end else if (bus.out_ready) begin
                exp_t e;
                e = q.pop_front();
                chk($sformatf("b%0d_re", beat_no), bus.re_m, e.re);
                chk($sformatf("b%0d_im", beat_no), bus.im_m, e.im);
                chk($sformatf("b%0d_sof_eof_err", beat_no),
                    {157'd0, bus.out_sof, bus.out_eof, bus.frm_err},
                    {157'd0, e.sof, e.eof, e.err});
                beat_no++;
            end else begin
                chk("hold_re", bus.re_m, q[0].re);
                chk("hold_im", bus.im_m, q[0].im);
                chk("hold_sof_eof",
                    {158'd0, bus.out_sof, bus.out_eof},
                    {158'd0, q[0].sof, q[0].eof});
            end
        end
    end

    initial begin
        vec_t re_in, im_in, re_f, im_f, re_i, im_i, z, sre, sim;
        re_in = mk(5, 11, 100, -3, 1, -50, 30);
        im_in = mk(7, -13, -20, 9, 2, 60, 40);
        re_f  = mk(5, 11, -20, 9, 1, 60, 40);
        im_f  = mk(7, -13, -100, 3, 2, 50, -30);
        re_i  = mk(5, 11, 20, -9, 1, -60, -40);
        im_i  = mk(7, -13, 100, -3, 2, -50, 30);
        z     = '0;
        sre   = mk(0, 0, 0, -512, 0, 0, 0);
        sim   = mk(0, 0, 0, 0, 0, 0, 0);

        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_inv    = 1'b0;
        bus.re        = '0;
        bus.im        = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {154'd0, bus.out_valid, bus.out_sof, bus.out_eof,
                         bus.frm_err, bus.in_ready, 1'b0},
            {154'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        chk("rst_re_m", bus.re_m, z);
        chk("rst_im_m", bus.im_m, z);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // forward frame
        for (int k = 0; k < 4; k++)
            send(k == 0, 1'b0, re_in, im_in, k == 0, k == 3, 1'b0, re_f, im_f);
        // inverse frame
        for (int k = 0; k < 4; k++)
            send(k == 0, 1'b1, re_in, im_in, k == 0, k == 3, 1'b0, re_i, im_i);
        // forward result back through inverse restores the input
        for (int k = 0; k < 4; k++)
            send(k == 0, 1'b1, re_f, im_f, k == 0, k == 3, 1'b0, re_in, im_in);

        // backpressure mid-frame; lane 0 tags each beat
        fork
            begin
                for (int k = 0; k < 4; k++)
                    send(k == 0, 1'b0, mk(20 + k, 11, 100, -3, 1, -50, 30),
                         im_in, k == 0, k == 3, 1'b0,
                         mk(20 + k, 11, -20, 9, 1, 60, 40), im_f);
            end
            begin
                int base;
                int w;
                base = acc;
                w = 0;
                while (acc < base + 2 && w < 100) begin
                    @(posedge clk);
                    #2;
                    w++;
                end
                bus.out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    chk("stall_in_ready", {159'd0, bus.in_ready}, 160'd0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // sof on beat 2 restarts the frame inverse; then a stray IDLE beat
        send(1'b1, 1'b0, re_in, im_in, 1'b1, 1'b0, 1'b0, re_f, im_f);
        send(1'b0, 1'b1, re_in, im_in, 1'b0, 1'b0, 1'b0, re_f, im_f);
        send(1'b1, 1'b1, re_in, im_in, 1'b1, 1'b0, 1'b1, re_i, im_i);
        send(1'b0, 1'b0, re_in, im_in, 1'b0, 1'b0, 1'b1, re_i, im_i);
        send(1'b0, 1'b0, re_in, im_in, 1'b0, 1'b0, 1'b1, re_i, im_i);
        send(1'b0, 1'b0, re_in, im_in, 1'b0, 1'b1, 1'b1, re_i, im_i);
        send(1'b0, 1'b1, re_in, im_in, 1'b0, 1'b0, 1'b1, re_f, im_f);

        // saturation on lane 7, forward
        send(1'b1, 1'b0, sre, sim, 1'b1, 1'b0, 1'b1,
             z, mk(0, 0, 0, SATV, 0, 0, 0));
        for (int k = 1; k < 4; k++)
            send(1'b0, 1'b0, z, z, 1'b0, k == 3, 1'b1, z, z);

        // async reset after beat 1
        send(1'b1, 1'b1, re_in, im_in, 1'b1, 1'b0, 1'b1, re_i, im_i);
        send(1'b0, 1'b0, re_in, im_in, 1'b0, 1'b0, 1'b1, re_i, im_i);
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_ctrl", {156'd0, bus.out_valid, bus.out_sof, bus.out_eof,
                          bus.frm_err},
            160'd0);
        chk("arst_re_m", bus.re_m, z);
        chk("arst_im_m", bus.im_m, z);
        q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++)
            send(k == 0, 1'b0, re_in, im_in, k == 0, k == 3, 1'b0, re_f, im_f);

        repeat (4) @(posedge clk);
        #1;
        chk("drain_queue", 160'(q.size()), 160'd0);
        chk("idle_valid", {159'd0, bus.out_valid}, 160'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
